instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream neighbour of the control unit: owns the program counter, fetches 32-bit instructions from instruction ROM over a req/valid handshake, and presents a stable instruction to the control unit.
- Applies the control word's PC-select field (PS, controlWord[31:30]) after each instruction executes.
- Sequenced by a 4-state machine so the control unit's registered decode has one full cycle before the datapath executes.

Parameters:
- PC_WIDTH, 64, width of PC, in_bus and branch offset.
- INSTR_WIDTH, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset (must be a multiple of 4).
- TIMEOUT_CYCLES, 16, fetch watchdog limit; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request, held high until imem_valid.
- imem_addr  out  PC_WIDTH  fetch address (= pc).
- imem_valid  in  1  ROM response valid.
- imem_rdata  in  INSTR_WIDTH  ROM read data.
- ps  in  2  PC select from controlWord[31:30].
- branch_offset  in  PC_WIDTH  sign-extended word offset (constant output).
- in_bus  in  PC_WIDTH  register-A value for PC load (BR).
- stall  in  1  holds EXECUTE (multi-cycle datapath op).
- instruction  out  INSTR_WIDTH  latched instruction to the control unit.
- instr_valid  out  1  high in DECODE and EXECUTE.
- pc  out  PC_WIDTH  current PC.
- pc_plus4  out  PC_WIDTH  pc + 4, combinational, for BL link.
- align_fault  out  1  one-cycle pulse on a misaligned PC load.
- fetch_error  out  1  watchdog pulse (optional feature only).

Behaviour:
- States: FETCH, WAIT, DECODE, EXECUTE. Encoding is free.
- Reset (rst=1 at posedge, any state): pc=RESET_PC, state=FETCH, instruction=0, imem_req=0, instr_valid=0, align_fault=0, fetch_error=0. Reset overrides all other inputs, including in-flight fetches. The ROM shares rst and drops pending requests.
- FETCH: imem_req=1, imem_addr=pc. Next state is WAIT.
- WAIT: imem_req stays 1 and addr stays stable.
  - On imem_valid=1: instruction<=imem_rdata, imem_req<=0, next state DECODE.
  - imem_valid in any other state is ignored.
- DECODE: exactly one cycle; instruction is held stable so the control unit registers the control word. Next state is EXECUTE.
- EXECUTE: while stall=1, hold all state. At the first cycle with stall=0, update pc by ps and go to FETCH:
  - 00: hold pc. Re-fetches the same address; used for halt/spin.
  - 01: pc <= pc + 4.
  - 10: pc <= {in_bus[PC_WIDTH-1:2], 2'b00}. If in_bus[1:0] != 0, pulse align_fault=1 for one cycle.
  - 11: pc <= pc + (branch_offset << 2). Two's-complement, truncated to PC_WIDTH.
- All PC arithmetic wraps modulo 2^PC_WIDTH; no overflow flag.
- Minimum latency per instruction is 4 cycles with a zero-wait ROM: FETCH, WAIT (valid same cycle), DECODE, EXECUTE.
- instruction changes only on WAIT->DECODE or on reset.
- ps, branch_offset and in_bus are sampled only in EXECUTE with stall=0; values at all other times are don't-care.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT and clears on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES without imem_valid: pulse fetch_error for 1 cycle, drop imem_req for that cycle, and return to FETCH (re-issue at the same pc).
  - A valid arriving on the same cycle as the timeout wins: no error is raised.
- Undefined: no counter is built, fetch_error is tied to 0, and WAIT is held indefinitely.

Test Plan:
- Reset then zero-wait ROM returning 32'h91019004 at addr 0, ps=01 → imem_addr=0; instruction=32'h91019004 in DECODE; pc=4 after EXECUTE; next imem_addr=4. Total 4 cycles.
- ROM delays valid 3 cycles at pc=8 → imem_req high and addr=8 for all WAIT cycles; instruction unchanged until valid arrives.
- pc=0x40, ps=11, branch_offset=-7 (64'hFFFF_FFFF_FFFF_FFF9) → pc=0x24. Repeat at pc=0, offset=-1 → pc=64'hFFFF_FFFF_FFFF_FFFC (wrap).
- ps=10, in_bus=0x1003 → pc=0x1000, align_fault high exactly 1 cycle. With in_bus=0x2000 → no fault.
- stall=1 for 5 cycles in EXECUTE with ps=01 → pc unchanged and instr_valid held. pc advances by 4 on the cycle stall drops.
- rst asserted in WAIT with a late imem_valid → pc=RESET_PC and state FETCH next cycle; the late data is never latched.
- (FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16) no valid for 16 cycles → fetch_error pulse, re-request at the same address.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Instruction-ROM fetch channel: the fetch unit drives req/addr and the
// ROM answers with valid/rdata.
interface instr_fetch_unit_if #(
    parameter int PC_WIDTH    = 64,
    parameter int INSTR_WIDTH = 32
);
    logic                   req;
    logic [PC_WIDTH-1:0]    addr;
    logic                   valid;
    logic [INSTR_WIDTH-1:0] rdata;

    modport master (output req, output addr, input valid, input rdata);
    modport slave  (input req, input addr, output valid, output rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches from instruction ROM over a
// req/valid handshake and holds the instruction stable for the control unit.
// Sequence per instruction: FETCH -> WAIT -> DECODE -> EXECUTE.
// Optional macro FETCH_TIMEOUT_EN adds a WAIT-state watchdog that pulses
// fetch_error and re-issues the request at the same PC.
module instr_fetch_unit #(
    parameter int                  PC_WIDTH       = 64,
    parameter int                  INSTR_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC       = '0,
    parameter int                  TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_fetch_unit_if.master     imem,
    input  logic [1:0]             ps,
    input  logic [PC_WIDTH-1:0]    branch_offset,
    input  logic [PC_WIDTH-1:0]    in_bus,
    input  logic                   stall,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [PC_WIDTH-1:0]    pc_plus4,
    output logic                   align_fault,
    output logic                   fetch_error
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_DECODE  = 2'd2,
        S_EXECUTE = 2'd3
    } state_t;

    localparam logic [1:0] PS_HOLD   = 2'b00;
    localparam logic [1:0] PS_INC    = 2'b01;
    localparam logic [1:0] PS_LOAD   = 2'b10;
    localparam logic [1:0] PS_BRANCH = 2'b11;

    state_t              state;
    state_t              state_nxt;
    logic [PC_WIDTH-1:0] pc_nxt;
    logic                fault_nxt;
    logic                timeout_hit;
    logic                exec_done;

    // An instruction retires on the first non-stalled EXECUTE cycle.
    assign exec_done = (state == S_EXECUTE) && !stall;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Watchdog counts WAIT cycles; it is zero on every entry to WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state != S_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Timeout cycle: request is dropped and, unless valid shows up in the
    // same cycle, the fetch is abandoned and re-issued.
    assign timeout_hit = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; valid beats the watchdog when both occur together.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:   state_nxt = S_WAIT;
            S_WAIT: begin
                if (imem.valid) begin
                    state_nxt = S_DECODE;
                end else if (timeout_hit) begin
                    state_nxt = S_FETCH;
                end
            end
            S_DECODE:  state_nxt = S_EXECUTE;
            S_EXECUTE: begin
                if (!stall) begin
                    state_nxt = S_FETCH;
                end
            end
            default:   state_nxt = S_FETCH;
        endcase
    end

    // Moore-style outputs; request is masked while reset is held since the
    // ROM drops pending requests on the same reset.
    always_comb begin
        imem.req    = 1'b0;
        instr_valid = 1'b0;
        fetch_error = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH:   imem.req    = 1'b1;
                S_WAIT: begin
                    imem.req    = !timeout_hit;
                    fetch_error = timeout_hit && !imem.valid;
                end
                S_DECODE:  instr_valid = 1'b1;
                S_EXECUTE: instr_valid = 1'b1;
                default:   imem.req    = 1'b0;
            endcase
        end
    end

    // PC select applied when EXECUTE retires; all arithmetic wraps.
    always_comb begin
        pc_nxt    = pc;
        fault_nxt = 1'b0;
        if (exec_done) begin
            case (ps)
                PS_HOLD:   pc_nxt = pc;
                PS_INC:    pc_nxt = pc_plus4;
                PS_LOAD: begin
                    pc_nxt    = {in_bus[PC_WIDTH-1:2], 2'b00};
                    fault_nxt = |in_bus[1:0];
                end
                PS_BRANCH: pc_nxt = pc + (branch_offset << 2);
                default:   pc_nxt = pc;
            endcase
        end
    end

    // PC, latched instruction and align-fault pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            instruction <= '0;
            align_fault <= 1'b0;
        end else begin
            pc          <= pc_nxt;
            align_fault <= fault_nxt;
            if ((state == S_WAIT) && imem.valid) begin
                instruction <= imem.rdata;
            end
        end
    end

    assign imem.addr = pc;
    assign pc_plus4  = pc + PC_WIDTH'(4);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a table of per-instruction vectors
// chained from PC 0, plus hand sequences for reset-in-WAIT and the watchdog.
module tb_instr_fetch_unit;

    localparam int PW = 64;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    ps = '0;
    logic [PW-1:0] branch_offset = '0;
    logic [PW-1:0] in_bus = '0;
    logic          stall = 1'b0;
    logic [IW-1:0] instruction;
    logic          instr_valid;
    logic [PW-1:0] pc;
    logic [PW-1:0] pc_plus4;
    logic          align_fault;
    logic          fetch_error;

    instr_fetch_unit_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) imem ();

    instr_fetch_unit #(
        .PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC('0), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .imem(imem.master), .ps(ps),
        .branch_offset(branch_offset), .in_bus(in_bus), .stall(stall),
        .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
        .pc_plus4(pc_plus4), .align_fault(align_fault), .fetch_error(fetch_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] rdata;
        int            wait_n;
        logic [1:0]    ps;
        logic [PW-1:0] off;
        logic [PW-1:0] inbus;
        int            stall_n;
        logic [PW-1:0] exp_pc;
        logic          exp_fault;
    } vec_t;

    vec_t          vecs[12];
    int            checks = 0;
    int            errors = 0;
    logic [PW-1:0] cur_pc = '0;
    logic [IW-1:0] prev_instr = '0;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one instruction starting at a negedge in FETCH, ends at the
    // negedge of the following FETCH.
    task automatic run_instr(input vec_t v);
        chk("fetch_req", imem.req, 1);
        chk("fetch_addr", imem.addr, cur_pc);
        chk("fetch_ivalid", instr_valid, 0);
        imem.valid = 1'b0;
        step();
        chk("fault_width", align_fault, 0);
        for (int i = 0; i < v.wait_n; i++) begin
            chk("wait_req", imem.req, 1);
            chk("wait_addr", imem.addr, cur_pc);
            chk("wait_instr_held", instruction, prev_instr);
            step();
        end
        chk("wait_req_last", imem.req, 1);
        imem.valid = 1'b1;
        imem.rdata = v.rdata;
        step();
        chk("decode_instr", instruction, v.rdata);
        chk("decode_ivalid", instr_valid, 1);
        chk("decode_req", imem.req, 0);
        // junk on the bus outside WAIT must be ignored
        imem.rdata = ~v.rdata;
        ps = ~v.ps;
        step();
        ps = v.ps;
        branch_offset = v.off;
        in_bus = v.inbus;
        stall = (v.stall_n > 0);
        chk("exec_ivalid", instr_valid, 1);
        chk("exec_pc_plus4", pc_plus4, cur_pc + 64'd4);
        for (int i = 0; i < v.stall_n; i++) begin
            step();
            chk("stall_pc", pc, cur_pc);
            chk("stall_ivalid", instr_valid, 1);
            chk("stall_instr", instruction, v.rdata);
        end
        stall = 1'b0;
        step();
        imem.valid = 1'b0;
        chk("next_pc", pc, v.exp_pc);
        chk("align_fault", align_fault, v.exp_fault);
        chk("instr_kept", instruction, v.rdata);
        chk("fetch_ivalid_after", instr_valid, 0);
        cur_pc = v.exp_pc;
        prev_instr = v.rdata;
    endtask

    initial begin
        vecs[0]  = '{32'h91019004, 0, 2'b01, 64'd0, 64'd0, 0, 64'h4, 1'b0};
        vecs[1]  = '{32'h11111111, 0, 2'b01, 64'd0, 64'd0, 0, 64'h8, 1'b0};
        vecs[2]  = '{32'h22222222, 3, 2'b10, 64'd0, 64'h40, 0, 64'h40, 1'b0};
        vecs[3]  = '{32'h33333333, 0, 2'b11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 0, 64'h24, 1'b0};
        vecs[4]  = '{32'h44444444, 1, 2'b10, 64'd0, 64'h1003, 0, 64'h1000, 1'b1};
        vecs[5]  = '{32'h55555555, 0, 2'b10, 64'd0, 64'h2000, 0, 64'h2000, 1'b0};
        vecs[6]  = '{32'h66666666, 0, 2'b01, 64'd0, 64'd0, 5, 64'h2004, 1'b0};
        vecs[7]  = '{32'h77777777, 2, 2'b00, 64'd0, 64'd0, 0, 64'h2004, 1'b0};
        vecs[8]  = '{32'h88888888, 0, 2'b10, 64'd0, 64'd0, 0, 64'h0, 1'b0};
        vecs[9]  = '{32'h99999999, 0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vecs[10] = '{32'hAAAAAAAA, 0, 2'b01, 64'd0, 64'd0, 0, 64'h0, 1'b0};
        vecs[11] = '{32'hBBBBBBBB, 1, 2'b11, 64'h3, 64'd0, 0, 64'hC, 1'b0};

        imem.valid = 1'b0;
        imem.rdata = '0;

        // reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_pc", pc, 0);
        chk("rst_instr", instruction, 0);
        chk("rst_req", imem.req, 0);
        chk("rst_ivalid", instr_valid, 0);
        chk("rst_fault", align_fault, 0);
        chk("rst_ferr", fetch_error, 0);
        rst = 1'b0;
        #1;
        chk("rst_release_req", imem.req, 1);

        for (int k = 0; k < 12; k++) begin
            run_instr(vecs[k]);
        end

        // reset hits WAIT while a late response arrives with it
        chk("pre_rst_addr", imem.addr, 64'hC);
        step();
        chk("pre_rst_wait_req", imem.req, 1);
        rst = 1'b1;
        imem.valid = 1'b1;
        imem.rdata = 32'hDEADBEEF;
        step();
        chk("wrst_pc", pc, 0);
        chk("wrst_instr", instruction, 0);
        chk("wrst_req", imem.req, 0);
        chk("wrst_ivalid", instr_valid, 0);
        rst = 1'b0;
        imem.valid = 1'b0;
        #1;
        chk("wrst_fetch_req", imem.req, 1);
        chk("wrst_fetch_addr", imem.addr, 0);
        cur_pc = '0;
        prev_instr = '0;
        run_instr('{32'hCAFEF00D, 0, 2'b01, 64'd0, 64'd0, 0, 64'h4, 1'b0});

`ifdef FETCH_TIMEOUT_EN
        // watchdog: 16 silent WAIT cycles, then error and re-issue
        step();
        for (int i = 0; i < 16; i++) begin
            chk("wd_req", imem.req, 1);
            chk("wd_no_err", fetch_error, 0);
            step();
        end
        chk("wd_err", fetch_error, 1);
        chk("wd_req_drop", imem.req, 0);
        step();
        chk("wd_err_width", fetch_error, 0);
        chk("wd_reissue_req", imem.req, 1);
        chk("wd_reissue_addr", imem.addr, 64'h4);
        run_instr('{32'h0BADC0DE, 0, 2'b01, 64'd0, 64'd0, 0, 64'h8, 1'b0});
`else
        chk("ferr_tied", fetch_error, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
